hex_display_arbiter: RTL and testbench

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

---
 rtl/hex_display_arbiter.sv | 87 ++++++++
 tb/tb_hex_display_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin arbiter granting two requesters timed ownership of six 7-segment hex displays
// Ports:
//   clk_clk, reset_reset          : clock and synchronous active-high reset
//   req0_valid/req0_data/req0_ready : requester 0 handshake and 24-bit value (six hex nibbles)
//   req1_valid/req1_data/req1_ready : requester 1 handshake and 24-bit value
//   hex0_2_export, hex3_5_export  : active-low segments for digits 0..2 and 3..5, 7 bits per digit (g..a)
//   owner                         : requester currently or last granted
//   busy                          : high while a grant is being held
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        req0_valid,
    input  logic [23:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_data,
    output logic        req1_ready,
    output logic [20:0] hex0_2_export,
    output logic [20:0] hex3_5_export,
    output logic        owner,
    output logic        busy
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t      state;
    logic        rr_ptr;
    logic [25:0] cnt;
    logic        acc0, acc1;
    logic [23:0] data;
    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction
    // In HOLD the owner is always ready; in IDLE a sole requester wins, a tie goes to rr_ptr.
    always_comb begin
        req0_ready = (state == HOLD) ? ~owner : req0_valid & (~req1_valid | ~rr_ptr);
        req1_ready = (state == HOLD) ? owner : req1_valid & (~req0_valid | rr_ptr);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        data = acc1 ? req1_data : req0_data;
    end
    assign busy = (state == HOLD);
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            rr_ptr        <= 1'b0;
            cnt           <= '0;
            hex0_2_export <= '1;
            hex3_5_export <= '1;
        end else begin
            if (state == IDLE) begin
                if (acc0 | acc1) begin
                    state  <= HOLD;
                    owner  <= acc1;
                    rr_ptr <= ~acc1;
                    cnt    <= 26'(HOLD_CYCLES - 1);
                end
            end else if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 26'd1;
            end
            if (acc0 | acc1) begin
                hex0_2_export <= {seg(data[11:8]), seg(data[7:4]), seg(data[3:0])};
                hex3_5_export <= {seg(data[23:20]), seg(data[19:16]), seg(data[15:12])};
            end
        end
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed self-checking bench for hex_display_arbiter (HOLD_CYCLES=4 and =1)
module tb_hex_display_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, vb1;
    logic [23:0] d0, d1, db1;
    logic        r0, r1, own, busy;
    logic [20:0] h02, h35;
    logic        rb0, rb1, ownb, busyb;
    logic [20:0] hb02, hb35;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        e;

    always #5 clk = ~clk;

    hex_display_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .hex0_2_export(h02), .hex3_5_export(h35), .owner(own), .busy(busy)
    );

    hex_display_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk_clk(clk), .reset_reset(rst),
        .req0_valid(1'b0), .req0_data(24'h0), .req0_ready(rb0),
        .req1_valid(vb1), .req1_data(db1), .req1_ready(rb1),
        .hex0_2_export(hb02), .hex3_5_export(hb35), .owner(ownb), .busy(busyb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; vb1 = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; v0 = 1; v1 = 0; d0 = 24'h012345; vb1 = 0; d1 = 0; db1 = 0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (h02 !== 21'h1FFFFF) begin n_fail++; $display("FAIL reset_h02 got %h want 1fffff", h02); end
        n_checks++; if (h35 !== 21'h1FFFFF) begin n_fail++; $display("FAIL reset_h35 got %h want 1fffff", h35); end
        n_checks++; if (own !== 1'b0) begin n_fail++; $display("FAIL reset_owner got %b want 0", own); end
        v0 = 0;
        #1;
        n_checks++; if ({r0, r1} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {r0, r1}); end
        rst = 0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        v0 = 1; d0 = 24'h012345;
        #1;
        n_checks++; if ({r0, r1} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b want 10", {r0, r1}); end
        tick();
        v0 = 0;
        #1;
        n_checks++; if (h35 !== {7'h40, 7'h79, 7'h24}) begin n_fail++; $display("FAIL single_h35 got %h want %h", h35, {7'h40, 7'h79, 7'h24}); end
        n_checks++; if (h02 !== {7'h30, 7'h19, 7'h12}) begin n_fail++; $display("FAIL single_h02 got %h want %h", h02, {7'h30, 7'h19, 7'h12}); end
        n_checks++; if ({busy, own} !== 2'b10) begin n_fail++; $display("FAIL single_busy_owner got %b want 10", {busy, own}); end
        n_checks++; if ({r0, r1} !== 2'b10) begin n_fail++; $display("FAIL single_hold_ready got %b want 10", {r0, r1}); end
        tick(); tick(); tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_last_hold got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle got %b want 0", busy); end
        n_checks++; if (h35 !== {7'h40, 7'h79, 7'h24}) begin n_fail++; $display("FAIL single_display_hold got %h want %h", h35, {7'h40, 7'h79, 7'h24}); end
        n_checks++; if (own !== 1'b0) begin n_fail++; $display("FAIL single_owner_keep got %b want 0", own); end
    endtask

    task automatic test_encoding();
        do_reset();
        v0 = 1; d0 = 24'h89ABCD;
        tick();
        n_checks++; if (h35 !== {7'h00, 7'h10, 7'h08}) begin n_fail++; $display("FAIL enc_89A got %h want %h", h35, {7'h00, 7'h10, 7'h08}); end
        n_checks++; if (h02 !== {7'h03, 7'h46, 7'h21}) begin n_fail++; $display("FAIL enc_BCD got %h want %h", h02, {7'h03, 7'h46, 7'h21}); end
        d0 = 24'h67EF00;
        tick();
        v0 = 0;
        n_checks++; if (h35 !== {7'h02, 7'h78, 7'h06}) begin n_fail++; $display("FAIL enc_67E got %h want %h", h35, {7'h02, 7'h78, 7'h06}); end
        n_checks++; if (h02 !== {7'h0E, 7'h40, 7'h40}) begin n_fail++; $display("FAIL enc_F00 got %h want %h", h02, {7'h0E, 7'h40, 7'h40}); end
        tick(); tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL enc_no_reload_hold got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL enc_no_reload_idle got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        v0 = 1; v1 = 1; d0 = 24'h111111; d1 = 24'h222222;
        e = 0;
        for (int g = 0; g < 4; g++) begin
            #1;
            n_checks++; if ({busy, r0, r1} !== {1'b0, ~e, e}) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", g, {busy, r0, r1}, {1'b0, ~e, e}); end
            tick();
            for (int i = 0; i < 4; i++) begin
                n_checks++; if ({busy, own, r0, r1} !== {1'b1, e, ~e, e}) begin n_fail++; $display("FAIL rr_hold%0d_%0d got %b want %b", g, i, {busy, own, r0, r1}, {1'b1, e, ~e, e}); end
                tick();
            end
            e = ~e;
        end
        n_checks++; if (h02 !== {3{7'h24}}) begin n_fail++; $display("FAIL rr_display got %h want %h", h02, {3{7'h24}}); end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_last_cycle();
        do_reset();
        v0 = 1; d0 = 24'h012345;
        tick();
        v0 = 0;
        tick(); tick(); tick();
        v0 = 1; d0 = 24'hFFFFFF;
        #1;
        n_checks++; if ({busy, r0} !== 2'b11) begin n_fail++; $display("FAIL last_ready got %b want 11", {busy, r0}); end
        tick();
        v0 = 0;
        n_checks++; if ({h35, h02} !== {6{7'h0E}}) begin n_fail++; $display("FAIL last_display got %h want %h", {h35, h02}, {6{7'h0E}}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL last_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        v1 = 1; d1 = 24'h888888;
        #1;
        n_checks++; if ({r0, r1} !== 2'b01) begin n_fail++; $display("FAIL mid_sole_req1 got %b want 01", {r0, r1}); end
        tick();
        v1 = 0;
        n_checks++; if ({h35, h02, own} !== {42'h0, 1'b1}) begin n_fail++; $display("FAIL mid_shown got %h want %h", {h35, h02, own}, {42'h0, 1'b1}); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if ({h35, h02} !== {42{1'b1}}) begin n_fail++; $display("FAIL mid_blank got %h want %h", {h35, h02}, {42{1'b1}}); end
        n_checks++; if ({busy, own} !== 2'b00) begin n_fail++; $display("FAIL mid_busy_owner got %b want 00", {busy, own}); end
    endtask

    task automatic test_hold1();
        do_reset();
        vb1 = 1; db1 = 24'hABCDEF;
        for (int g = 0; g < 3; g++) begin
            #1;
            n_checks++; if ({busyb, rb0, rb1} !== 3'b001) begin n_fail++; $display("FAIL h1_idle%0d got %b want 001", g, {busyb, rb0, rb1}); end
            tick();
            n_checks++; if ({busyb, ownb, rb0, rb1} !== 4'b1101) begin n_fail++; $display("FAIL h1_hold%0d got %b want 1101", g, {busyb, ownb, rb0, rb1}); end
            tick();
        end
        vb1 = 0;
        n_checks++; if (hb02 !== {7'h21, 7'h06, 7'h0E}) begin n_fail++; $display("FAIL h1_display got %h want %h", hb02, {7'h21, 7'h06, 7'h0E}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_encoding();
        test_back_to_back();
        test_last_cycle();
        test_reset_mid_hold();
        test_hold1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
